qspi_xip_ctrl_ahbl: RTL and testbench

- Read-only execute-in-place (XIP) controller.
- Maps an external quad-SPI NOR flash (SST26WF080B-class) into AHB-Lite address space.
- A direct-mapped line cache sits in front of the flash. Misses refill a whole line with one Quad I/O Fast Read (0xEB).
- Sits on the system AHB-Lite bus as a slave. The pad-level SIO buffers are external.

---
 rtl/qspi_xip_ctrl_ahbl.sv | 213 +++++++++++++++++++++
 tb/tb_qspi_xip_ctrl_ahbl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_xip_ctrl_ahbl.sv
// Read-only execute-in-place controller: AHB-Lite slave with a direct-mapped
// line cache in front of a quad-SPI NOR flash. A miss refills one 16-byte line
// with a single Quad I/O Fast Read (0xEB) in SPI mode 0, sck = HCLK/2.
module qspi_xip_ctrl_ahbl #(
  parameter int NUM_LINES = 16,
  parameter int LINE_SIZE = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        sck,
  output logic        ce_n,
  input  logic [3:0]  din,
  output logic [3:0]  dout,
  output logic [3:0]  douten
);

  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = 20 - IDX_W;
  localparam int LINE_W = LINE_SIZE * 8;

  localparam logic [7:0] CMD_QIO_READ = 8'hEB;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_MODE  = 3'd3;
  localparam logic [2:0] S_DUMMY = 3'd4;
  localparam logic [2:0] S_DATA  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  // Data-phase bookkeeping
  logic              r_dp_valid;
  logic [23:2]       r_dp_addr;

  // Flash sequencer
  logic [2:0]        r_state;
  logic [4:0]        r_cnt;
  logic              r_sck;
  logic              r_ce_n;
  logic [3:0]        r_dout;
  logic [3:0]        r_douten;
  logic [LINE_W-1:0] r_line;

  // Cache arrays
  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [LINE_W-1:0]    r_data [NUM_LINES];

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [1:0]       w_word;
  logic [23:0]      w_fill_addr;
  logic             w_hit;
  logic             w_miss;
  logic             w_phase_last;
  logic [2:0]       w_nxt_state;
  logic [4:0]       w_nxt_cnt;
  logic             w_line_wr;
  logic             w_unused_bits;

  // Last sck index of each serial phase (phase length minus one).
  function automatic logic [4:0] f_last(input logic [2:0] st);
    case (st)
      S_CMD:   f_last = 5'd7;
      S_ADDR:  f_last = 5'd5;
      S_MODE:  f_last = 5'd1;
      S_DUMMY: f_last = 5'd3;
      S_DATA:  f_last = 5'd31;
      default: f_last = 5'd0;
    endcase
  endfunction

  function automatic logic [2:0] f_next(input logic [2:0] st);
    case (st)
      S_CMD:   f_next = S_ADDR;
      S_ADDR:  f_next = S_MODE;
      S_MODE:  f_next = S_DUMMY;
      S_DUMMY: f_next = S_DATA;
      S_DATA:  f_next = S_DONE;
      default: f_next = S_IDLE;
    endcase
  endfunction

  // Pads are driven as a whole nibble: all four during command/address/mode.
  function automatic logic [3:0] f_oe(input logic [2:0] st);
    f_oe = (st == S_CMD || st == S_ADDR || st == S_MODE) ? 4'hF : 4'h0;
  endfunction

  // Nibble presented on SIO for a given phase/position. WP#/HOLD# held high
  // while the command goes out serially on SIO0; the mode byte is 0x00.
  function automatic logic [3:0] f_dout(input logic [2:0] st, input logic [2:0] cnt,
                                        input logic [23:0] a);
    logic [2:0] sh;
    sh = 3'd5 - cnt;
    case (st)
      S_CMD:   f_dout = {3'b111, CMD_QIO_READ[3'd7 - cnt]};
      S_ADDR:  f_dout = a[{sh, 2'b00} +: 4];
      default: f_dout = 4'h0;
    endcase
  endfunction

  assign w_idx       = r_dp_addr[IDX_W+3:4];
  assign w_tag       = r_dp_addr[23:IDX_W+4];
  assign w_word      = r_dp_addr[3:2];
  assign w_fill_addr = {r_dp_addr[23:4], 4'h0};
  assign w_hit       = r_dp_valid && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_miss      = r_dp_valid && !w_hit && (r_state == S_IDLE);
  assign w_line_wr   = (r_state == S_DATA) && r_sck && w_phase_last;

  // Address bits above the 16 MB window, byte lanes and HTRANS[0] carry no meaning here.
  assign w_unused_bits = ^{HADDR[31:24], HADDR[1:0], HTRANS[0]};

  assign HREADYOUT = !r_dp_valid || ((r_state == S_IDLE) && w_hit);
  assign HRDATA    = ((r_state == S_IDLE) && w_hit) ? r_data[w_idx][{w_word, 5'b0} +: 32] : 32'h0;
  assign sck       = r_sck;
  assign ce_n      = r_ce_n;
  assign dout      = r_dout;
  assign douten    = r_douten;

  // Phase position bookkeeping: advance on each sck falling edge.
  always_comb begin
    w_phase_last = (r_cnt == f_last(r_state));
    w_nxt_state  = r_state;
    w_nxt_cnt    = r_cnt + 5'd1;
    if (w_phase_last) begin
      w_nxt_state = f_next(r_state);
      w_nxt_cnt   = 5'd0;
    end
  end

  // Track whether a read is in its data phase; held while wait states stall the bus.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_dp_valid <= 1'b0;
    end else if (HREADY) begin
      r_dp_valid <= HSEL && HTRANS[1] && !HWRITE;
    end
  end

  // Capture the address of each accepted transfer.
  always_ff @(posedge HCLK) begin
    if (HSEL && HTRANS[1] && HREADY) begin
      r_dp_addr <= HADDR[23:2];
    end
  end

  // Flash sequencer: sck toggles every HCLK; outputs move on the falling edge.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state  <= S_IDLE;
      r_cnt    <= 5'd0;
      r_sck    <= 1'b0;
      r_ce_n   <= 1'b1;
      r_dout   <= 4'h0;
      r_douten <= 4'h0;
      r_valid  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_miss) begin
            r_state  <= S_CMD;
            r_cnt    <= 5'd0;
            r_sck    <= 1'b0;
            r_ce_n   <= 1'b0;
            r_dout   <= f_dout(S_CMD, 3'd0, w_fill_addr);
            r_douten <= 4'hF;
          end
        end
        S_DONE: begin
          // Two HCLK with ce_n high before the next fill can begin.
          if (r_cnt == 5'd1) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        default: begin
          r_sck <= !r_sck;
          if (r_sck) begin
            r_state  <= w_nxt_state;
            r_cnt    <= w_nxt_cnt;
            r_dout   <= f_dout(w_nxt_state, w_nxt_cnt[2:0], w_fill_addr);
            r_douten <= f_oe(w_nxt_state);
            r_ce_n   <= (w_nxt_state == S_DONE);
            if (w_line_wr) begin
              r_valid[w_idx] <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Assemble the line from din (high nibble of each byte first, little-endian bytes) and store it.
  always_ff @(posedge HCLK) begin
    if ((r_state == S_DATA) && !r_sck) begin
      r_line[{r_cnt[4:1], ~r_cnt[0], 2'b00} +: 4] <= din;
    end
    if (w_line_wr) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= r_line;
    end
  end

endmodule

// File: tb/tb_qspi_xip_ctrl_ahbl.sv
// Bench for qspi_xip_ctrl_ahbl: behavioural quad-SPI flash, cache reference
// model, directed scenarios followed by randomized reads/writes.
module tb_qspi_xip_ctrl_ahbl;

  localparam int NL = 16;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        sck;
  logic        ce_n;
  logic [3:0]  din = 4'h0;
  logic [3:0]  dout;
  logic [3:0]  douten;

  assign HREADY = HREADYOUT;

  always #5 HCLK = ~HCLK;

  qspi_xip_ctrl_ahbl #(.NUM_LINES(NL), .LINE_SIZE(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA),
    .sck(sck), .ce_n(ce_n), .din(din), .dout(dout), .douten(douten)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- flash model ----------------
  int flash_mode = 0;

  function automatic logic [7:0] flash_byte(input int unsigned i);
    int unsigned h;
    h = i * 32'd2654435761;
    if (flash_mode == 0) return i[7:0];
    return h[31:24] ^ i[7:0];
  endfunction

  function automatic logic [3:0] flash_nibble(input logic [23:0] base, input int j);
    logic [7:0] b;
    b = flash_byte(32'(base) + 32'(j / 2));
    return (j % 2 == 0) ? b[7:4] : b[3:0];
  endfunction

  int         sck_n = 0;
  logic [7:0] cap_cmd = 8'h0;
  logic [23:0] cap_addr = 24'h0;
  int         fills = 0;
  int         proto_err = 0;
  int         mon_err = 0;

  always @(negedge ce_n) fills <= fills + 1;

  // Flash samples SIO on sck rising edges and checks the output-enable per phase.
  always @(posedge sck or posedge ce_n) begin
    if (ce_n) begin
      sck_n <= 0;
    end else begin
      if (sck_n >= 52) proto_err <= proto_err + 1;
      else if (sck_n < 8) begin
        cap_cmd <= {cap_cmd[6:0], dout[0]};
        if (dout[3:1] !== 3'b111 || douten !== 4'hF) proto_err <= proto_err + 1;
      end else if (sck_n < 14) begin
        cap_addr <= {cap_addr[19:0], dout};
        if (douten !== 4'hF) proto_err <= proto_err + 1;
      end else if (sck_n < 16) begin
        if (dout !== 4'h0 || douten !== 4'hF) proto_err <= proto_err + 1;
      end else if (douten !== 4'h0) proto_err <= proto_err + 1;
      sck_n <= sck_n + 1;
    end
  end

  // Flash drives read data after sck falling edges once the dummy cycles are over.
  always @(negedge sck) begin
    if (!ce_n && sck_n >= 20 && sck_n < 52) din <= flash_nibble(cap_addr, sck_n - 20);
  end

  // Output-enable is all or nothing; pads quiet and sck low while deselected.
  always @(negedge HCLK) begin
    if (douten !== 4'h0 && douten !== 4'hF) mon_err <= mon_err + 1;
    else if (ce_n && (douten !== 4'h0 || sck !== 1'b0)) mon_err <= mon_err + 1;
  end

  // ---------------- cache reference model ----------------
  bit          m_valid [NL];
  int unsigned m_tag   [NL];

  task automatic model_clear();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    int unsigned base;
    base = a & 32'h00FF_FFFC;
    return {flash_byte(base + 3), flash_byte(base + 2), flash_byte(base + 1), flash_byte(base)};
  endfunction

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    int unsigned idx;
    int unsigned tag;
    bit          hit;
    int          waits;
    int          f0;
    idx = (a[23:0] / 16) % NL;
    tag = a[23:0] / (16 * NL);
    hit = m_valid[idx] && (m_tag[idx] == tag);
    f0  = fills;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    waits = 0;
    while (HREADYOUT !== 1'b1 && waits < 400) begin
      @(posedge HCLK); #1;
      waits++;
    end
    d = HRDATA;
    check($sformatf("rdata@%h", a), d, exp_word(a));
    if (hit) begin
      check($sformatf("hit_waits@%h", a), waits, 0);
      check("hit_no_fill", fills - f0, 0);
    end else begin
      check($sformatf("miss_waits_104_110(%0d)@%h", waits, a), (waits >= 104 && waits <= 110), 1);
      check("miss_one_fill", fills - f0, 1);
      check("fill_cmd", cap_cmd, 8'hEB);
      check("fill_addr", cap_addr, {a[23:4], 4'h0});
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
    end
    @(posedge HCLK); #1;
  endtask

  task automatic do_write(input logic [31:0] a);
    int f0;
    f0 = fills;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    check("write_zero_wait", HREADYOUT, 1);
    @(posedge HCLK); #1;
    check("write_no_fill", fills - f0, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time observed over limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] ra;
    int          waits;

    HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'h0;
    model_clear();
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_hreadyout", HREADYOUT, 1);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_ce_n", ce_n, 1);
    check("rst_sck", sck, 0);
    check("rst_dout", dout, 4'h0);
    check("rst_douten", douten, 4'h0);
    HRESET = 1'b0;
    @(posedge HCLK); #1;

    // First miss, then the rest of the line hits.
    do_read(32'h0, d);   check("first_word", d, 32'h03020100);
    do_read(32'h4, d);   check("hit_w1", d, 32'h07060504);
    do_read(32'h8, d);   check("hit_w2", d, 32'h0B0A0908);
    do_read(32'hC, d);   check("hit_w3", d, 32'h0F0E0D0C);

    for (int i = 0; i < 4; i++) do_read(32'h10 + 32'(i * 4), d);
    for (int i = 0; i < 4; i++) do_read(32'h0 + 32'(i * 4), d);
    do_read(32'h20, d);  check("l2_w0", d, 32'h23222120);
    do_read(32'h24, d);  check("l2_w1", d, 32'h27262524);
    do_read(32'h28, d);  check("l2_w2", d, 32'h2B2A2928);
    do_read(32'h2C, d);  check("l2_w3", d, 32'h2F2E2D2C);

    // Conflict on index 0.
    do_read(32'h0, d);
    do_read(32'(NL * 16), d);
    do_read(32'h0, d);   check("conflict_reread", d, 32'h03020100);

    // Pipelined: hit at 0x24 with 0x30 issued in its data phase.
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h24;
    @(posedge HCLK); #1;
    check("pipe_hit_ready", HREADYOUT, 1);
    check("pipe_hit_data", HRDATA, 32'h27262524);
    HADDR = 32'h30;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    waits = 0;
    while (HREADYOUT !== 1'b1 && waits < 400) begin
      @(posedge HCLK); #1;
      waits++;
    end
    check("pipe_miss_waited", (waits >= 104 && waits <= 110), 1);
    check("pipe_miss_data", HRDATA, 32'h33323130);
    m_valid[3] = 1'b1; m_tag[3] = 0;
    @(posedge HCLK); #1;

    // Reset in the middle of a fill.
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h40;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    repeat (20) @(posedge HCLK);
    #1;
    check("midfill_active_ce_n", ce_n, 0);
    check("midfill_active_douten", douten, 4'hF);
    HRESET = 1'b1;
    #1;
    check("abort_ce_n", ce_n, 1);
    check("abort_douten", douten, 4'h0);
    check("abort_sck", sck, 0);
    check("abort_hreadyout", HREADYOUT, 1);
    model_clear();
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    @(posedge HCLK); #1;
    do_read(32'h40, d);  check("after_abort", d, 32'h43424140);
    do_read(32'h0, d);

    // Randomized traffic against a scrambled flash image.
    flash_mode = 1;
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    model_clear();
    @(posedge HCLK); #1;
    for (int k = 0; k < 60; k++) begin
      ra = 32'(((int'($urandom_range(0, 2)) * NL + int'($urandom_range(0, 5))) * 16)
                + int'($urandom_range(0, 3)) * 4);
      ra[31:24] = 8'($urandom_range(0, 255));
      ra[1:0]   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) do_write(ra);
      else do_read(ra, d);
    end

    check("douten_monitor", mon_err, 0);
    check("flash_protocol", proto_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
